udt_tx_arbiter: RTL and testbench

//  Packet-level arbiter sharing the single UDP transmit stream (udp_tx_*) between two UDT requesters:
//  the control-packet source (ACK/NAK/keep-alive) and the data-packet source.

---
 rtl/udt_pkg.sv | 11 +
 rtl/udt_tx_arbiter.sv | 122 ++++++++++++
 tb/tb_udt_tx_arbiter.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/udt_pkg.sv
// Shared constants for the UDT transmit path: arbiter state encoding and AXIS widths.
package udt_pkg;
  localparam int AXIS_DATA_W = 64;
  localparam int AXIS_KEEP_W = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_CTRL = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;
endpackage

// File: rtl/udt_tx_arbiter.sv
// Packet-level arbiter sharing the UDP transmit stream between the UDT control and data sources.
// Grants are whole packets; header fields are latched at grant and held for the packet.
module udt_tx_arbiter
  import udt_pkg::*;
#(
  parameter logic [47:0] FPGA_MAC_SRC   = 48'hba0203040506,
  parameter logic [31:0] FPGA_IP_SRC    = 32'hc0a8006f,
  parameter logic [31:0] PORT           = 32'd10086,
  parameter int          MAX_CTRL_BURST = 4
) (
  input  logic                   udp_clk,
  input  logic                   udp_areset,
  input  logic                   ctrl_tvalid,
  output logic                   ctrl_tready,
  input  logic                   ctrl_tlast,
  input  logic [AXIS_DATA_W-1:0] ctrl_tdata,
  input  logic [AXIS_KEEP_W-1:0] ctrl_tkeep,
  input  logic                   data_tvalid,
  output logic                   data_tready,
  input  logic                   data_tlast,
  input  logic [AXIS_DATA_W-1:0] data_tdata,
  input  logic [AXIS_KEEP_W-1:0] data_tkeep,
  input  logic [47:0]            cfg_mac_dest,
  input  logic [31:0]            cfg_ip_dest,
  input  logic [15:0]            cfg_port_dest,
  output logic                   udp_tx_tvalid,
  input  logic                   udp_tx_tready,
  output logic                   udp_tx_tlast,
  output logic [AXIS_DATA_W-1:0] udp_tx_tdata,
  output logic [AXIS_KEEP_W-1:0] udp_tx_tkeep,
  output logic [47:0]            udp_tx_mac_src,
  output logic [47:0]            udp_tx_mac_dest,
  output logic [31:0]            udp_tx_ip_src,
  output logic [31:0]            udp_tx_ip_dest,
  output logic [15:0]            udp_tx_port_src,
  output logic [15:0]            udp_tx_port_dest,
  output logic [31:0]            ctrl_pkt_cnt,
  output logic [31:0]            data_pkt_cnt
);

  localparam logic [3:0] BURST_LIM = 4'(MAX_CTRL_BURST);

  arb_state_t state;
  logic [3:0] starve_cnt;
  logic       ctrl_done, data_done, ctrl_win;

  assign udp_tx_mac_src  = FPGA_MAC_SRC;
  assign udp_tx_ip_src   = FPGA_IP_SRC;
  assign udp_tx_port_src = PORT[15:0];

  // Ctrl wins unless data is waiting and ctrl has used up its burst allowance.
  assign ctrl_win = ctrl_tvalid && (!data_tvalid || (starve_cnt < BURST_LIM));

  always_comb begin
    udp_tx_tvalid = 1'b0;
    udp_tx_tlast  = 1'b0;
    udp_tx_tdata  = '0;
    udp_tx_tkeep  = '0;
    ctrl_tready   = 1'b0;
    data_tready   = 1'b0;
    case (state)
      ARB_CTRL: begin
        udp_tx_tvalid = ctrl_tvalid;
        udp_tx_tlast  = ctrl_tlast;
        udp_tx_tdata  = ctrl_tdata;
        udp_tx_tkeep  = ctrl_tkeep;
        ctrl_tready   = udp_tx_tready;
      end
      ARB_DATA: begin
        udp_tx_tvalid = data_tvalid;
        udp_tx_tlast  = data_tlast;
        udp_tx_tdata  = data_tdata;
        udp_tx_tkeep  = data_tkeep;
        data_tready   = udp_tx_tready;
      end
      default: ;
    endcase
  end

  assign ctrl_done = (state == ARB_CTRL) && ctrl_tvalid && udp_tx_tready && ctrl_tlast;
  assign data_done = (state == ARB_DATA) && data_tvalid && udp_tx_tready && data_tlast;

  always_ff @(posedge udp_clk) begin
    if (udp_areset) begin
      state            <= ARB_IDLE;
      starve_cnt       <= '0;
      udp_tx_mac_dest  <= '0;
      udp_tx_ip_dest   <= '0;
      udp_tx_port_dest <= '0;
      ctrl_pkt_cnt     <= '0;
      data_pkt_cnt     <= '0;
    end else begin
      case (state)
        ARB_IDLE: begin
          if (ctrl_win || data_tvalid) begin
            udp_tx_mac_dest  <= cfg_mac_dest;
            udp_tx_ip_dest   <= cfg_ip_dest;
            udp_tx_port_dest <= cfg_port_dest;
          end
          if (ctrl_win) begin
            state <= ARB_CTRL;
            if (!data_tvalid)                 starve_cnt <= '0;
            else if (starve_cnt < BURST_LIM)  starve_cnt <= starve_cnt + 4'd1;
          end else if (data_tvalid) begin
            state      <= ARB_DATA;
            starve_cnt <= '0;
          end
        end
        ARB_CTRL: if (ctrl_done) begin
          state        <= ARB_IDLE;
          ctrl_pkt_cnt <= ctrl_pkt_cnt + 32'd1;
        end
        ARB_DATA: if (data_done) begin
          state        <= ARB_IDLE;
          data_pkt_cnt <= data_pkt_cnt + 32'd1;
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_udt_tx_arbiter.sv
// Directed bench for udt_tx_arbiter: grant timing, burst fairness, stalls, header latch, reset, throughput.
module tb_udt_tx_arbiter;
  logic        udp_clk = 1'b0;
  logic        udp_areset;
  logic        ctrl_tvalid, ctrl_tready, ctrl_tlast;
  logic [63:0] ctrl_tdata;
  logic [7:0]  ctrl_tkeep;
  logic        data_tvalid, data_tready, data_tlast;
  logic [63:0] data_tdata;
  logic [7:0]  data_tkeep;
  logic [47:0] cfg_mac_dest;
  logic [31:0] cfg_ip_dest;
  logic [15:0] cfg_port_dest;
  logic        udp_tx_tvalid, udp_tx_tready, udp_tx_tlast;
  logic [63:0] udp_tx_tdata;
  logic [7:0]  udp_tx_tkeep;
  logic [47:0] udp_tx_mac_src, udp_tx_mac_dest;
  logic [31:0] udp_tx_ip_src, udp_tx_ip_dest;
  logic [15:0] udp_tx_port_src, udp_tx_port_dest;
  logic [31:0] ctrl_pkt_cnt, data_pkt_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 udp_clk = ~udp_clk;

  udt_tx_arbiter dut (
    .udp_clk(udp_clk), .udp_areset(udp_areset),
    .ctrl_tvalid(ctrl_tvalid), .ctrl_tready(ctrl_tready), .ctrl_tlast(ctrl_tlast),
    .ctrl_tdata(ctrl_tdata), .ctrl_tkeep(ctrl_tkeep),
    .data_tvalid(data_tvalid), .data_tready(data_tready), .data_tlast(data_tlast),
    .data_tdata(data_tdata), .data_tkeep(data_tkeep),
    .cfg_mac_dest(cfg_mac_dest), .cfg_ip_dest(cfg_ip_dest), .cfg_port_dest(cfg_port_dest),
    .udp_tx_tvalid(udp_tx_tvalid), .udp_tx_tready(udp_tx_tready), .udp_tx_tlast(udp_tx_tlast),
    .udp_tx_tdata(udp_tx_tdata), .udp_tx_tkeep(udp_tx_tkeep),
    .udp_tx_mac_src(udp_tx_mac_src), .udp_tx_mac_dest(udp_tx_mac_dest),
    .udp_tx_ip_src(udp_tx_ip_src), .udp_tx_ip_dest(udp_tx_ip_dest),
    .udp_tx_port_src(udp_tx_port_src), .udp_tx_port_dest(udp_tx_port_dest),
    .ctrl_pkt_cnt(ctrl_pkt_cnt), .data_pkt_cnt(data_pkt_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge udp_clk);
    #1;
  endtask

  task automatic rst();
    udp_areset  = 1'b1;
    ctrl_tvalid = 1'b0; ctrl_tlast = 1'b0; ctrl_tdata = '0; ctrl_tkeep = 8'hff;
    data_tvalid = 1'b0; data_tlast = 1'b0; data_tdata = '0; data_tkeep = 8'h0f;
    udp_tx_tready = 1'b1;
    tick();
    tick();
    udp_areset = 1'b0;
  endtask

  initial begin
    int ci, di, nst, cyc, nf, last_c, prev_c, bad_gap;
    logic cf, df;
    logic [7:0] ord [10];
    int st [10];

    cfg_mac_dest = 48'h112233445566; cfg_ip_dest = 32'hc0a80002; cfg_port_dest = 16'd9000;
    rst();

    // reset state
    chk("rst_tvalid", 64'(udp_tx_tvalid), 64'd0);
    chk("rst_tlast", 64'(udp_tx_tlast), 64'd0);
    chk("rst_ctrl_tready", 64'(ctrl_tready), 64'd0);
    chk("rst_data_tready", 64'(data_tready), 64'd0);
    chk("rst_tdata", udp_tx_tdata, 64'd0);
    chk("rst_tkeep", 64'(udp_tx_tkeep), 64'd0);
    chk("rst_mac_dest", 64'(udp_tx_mac_dest), 64'd0);
    chk("rst_ip_dest", 64'(udp_tx_ip_dest), 64'd0);
    chk("rst_port_dest", 64'(udp_tx_port_dest), 64'd0);
    chk("rst_ctrl_cnt", 64'(ctrl_pkt_cnt), 64'd0);
    chk("rst_data_cnt", 64'(data_pkt_cnt), 64'd0);
    chk("mac_src", 64'(udp_tx_mac_src), 64'hba0203040506);
    chk("ip_src", 64'(udp_tx_ip_src), 64'hc0a8006f);
    chk("port_src", 64'(udp_tx_port_src), 64'd10086);

    // 1: 3-beat ctrl packet
    ctrl_tvalid = 1'b1; ctrl_tdata = 64'hc0; ctrl_tlast = 1'b0;
    #1;
    chk("t1_idle_tvalid", 64'(udp_tx_tvalid), 64'd0);
    chk("t1_idle_tready", 64'(ctrl_tready), 64'd0);
    for (int b = 0; b < 3; b++) begin
      tick();
      ctrl_tdata = 64'hc0 + 64'(b); ctrl_tlast = (b == 2);
      #1;
      chk("t1_tvalid", 64'(udp_tx_tvalid), 64'd1);
      chk("t1_tdata", udp_tx_tdata, 64'hc0 + 64'(b));
      chk("t1_tlast", 64'(udp_tx_tlast), (b == 2) ? 64'd1 : 64'd0);
      chk("t1_tkeep", 64'(udp_tx_tkeep), 64'hff);
      chk("t1_ctrl_tready", 64'(ctrl_tready), 64'd1);
      chk("t1_data_tready", 64'(data_tready), 64'd0);
    end
    tick();
    ctrl_tvalid = 1'b0; ctrl_tlast = 1'b0;
    #1;
    chk("t1_ctrl_cnt", 64'(ctrl_pkt_cnt), 64'd1);
    chk("t1_after_tvalid", 64'(udp_tx_tvalid), 64'd0);
    chk("t1_mac_dest", 64'(udp_tx_mac_dest), 64'h112233445566);
    chk("t1_port_dest", 64'(udp_tx_port_dest), 64'd9000);

    // 2: both sources streaming 2-beat packets
    rst();
    ctrl_tvalid = 1'b1; data_tvalid = 1'b1;
    ci = 0; di = 0; nst = 0; cyc = 0;
    while (nst < 10 && cyc < 200) begin
      ctrl_tdata = 64'hc0 + 64'(ci); ctrl_tlast = (ci == 1);
      data_tdata = 64'hd0 + 64'(di); data_tlast = (di == 1);
      #1;
      cf = ctrl_tvalid && ctrl_tready;
      df = data_tvalid && data_tready;
      if (cf && ci == 0) begin ord[nst] = "C"; st[nst] = cyc; nst++; end
      else if (df && di == 0) begin ord[nst] = "D"; st[nst] = cyc; nst++; end
      tick();
      if (cf) ci = 1 - ci;
      if (df) di = 1 - di;
      cyc++;
    end
    chk("t2_npkts", 64'(nst), 64'd10);
    chk("t2_first_grant", 64'(st[0]), 64'd1);
    for (int k = 0; k < nst; k++) begin
      chk($sformatf("t2_order%0d", k), 64'(ord[k]), (k == 4 || k == 9) ? 64'h44 : 64'h43);
      if (k > 0) chk($sformatf("t2_gap%0d", k), 64'(st[k] - st[k-1]), 64'd3);
    end

    // 3+4: downstream stall with data waiting, cfg change mid-packet
    rst();
    cfg_ip_dest = 32'hc0a80002;
    ctrl_tvalid = 1'b1; ctrl_tdata = 64'hc0; ctrl_tlast = 1'b0;
    data_tvalid = 1'b1; data_tdata = 64'hd0; data_tlast = 1'b1;
    tick();
    #1;
    chk("t3_ctrl_grant", 64'(ctrl_tready), 64'd1);
    chk("t3_ip_at_grant", 64'(udp_tx_ip_dest), 64'hc0a80002);
    tick();
    ctrl_tdata = 64'hc1; udp_tx_tready = 1'b0; cfg_ip_dest = 32'hc0a80003;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_stall_tvalid", 64'(udp_tx_tvalid), 64'd1);
      chk("t3_stall_tdata", udp_tx_tdata, 64'hc1);
      chk("t3_stall_ctrl_tready", 64'(ctrl_tready), 64'd0);
      chk("t3_stall_data_tready", 64'(data_tready), 64'd0);
      chk("t4_ip_held", 64'(udp_tx_ip_dest), 64'hc0a80002);
      tick();
    end
    udp_tx_tready = 1'b1;
    #1;
    chk("t3_resume_tdata", udp_tx_tdata, 64'hc1);
    tick();
    ctrl_tdata = 64'hc2; ctrl_tlast = 1'b1;
    tick();
    ctrl_tvalid = 1'b0; ctrl_tlast = 1'b0;
    #1;
    chk("t3_bubble_tvalid", 64'(udp_tx_tvalid), 64'd0);
    chk("t3_ctrl_cnt", 64'(ctrl_pkt_cnt), 64'd1);
    chk("t4_ip_before_regrant", 64'(udp_tx_ip_dest), 64'hc0a80002);
    tick();
    #1;
    chk("t3_data_grant", 64'(data_tready), 64'd1);
    chk("t3_data_tdata", udp_tx_tdata, 64'hd0);
    chk("t4_ip_new", 64'(udp_tx_ip_dest), 64'hc0a80003);
    tick();
    data_tvalid = 1'b0;
    #1;
    chk("t3_data_cnt", 64'(data_pkt_cnt), 64'd1);

    // 5: reset on beat 2 of a 5-beat data packet
    rst();
    ctrl_tvalid = 1'b1; ctrl_tlast = 1'b1;
    tick();
    #1;
    tick();
    ctrl_tvalid = 1'b0; ctrl_tlast = 1'b0;
    data_tvalid = 1'b1; data_tdata = 64'hd0; data_tlast = 1'b0;
    #1;
    chk("t5_ctrl_cnt_pre", 64'(ctrl_pkt_cnt), 64'd1);
    tick();
    #1;
    chk("t5_data_grant", 64'(data_tready), 64'd1);
    tick();
    data_tdata = 64'hd1; udp_areset = 1'b1;
    #1;
    tick();
    udp_areset = 1'b0;
    data_tdata = 64'he0; data_tlast = 1'b1;
    #1;
    chk("t5_tvalid", 64'(udp_tx_tvalid), 64'd0);
    chk("t5_data_tready", 64'(data_tready), 64'd0);
    chk("t5_ctrl_cnt", 64'(ctrl_pkt_cnt), 64'd0);
    chk("t5_data_cnt", 64'(data_pkt_cnt), 64'd0);
    tick();
    #1;
    chk("t5_regrant_tvalid", 64'(udp_tx_tvalid), 64'd1);
    chk("t5_regrant_tdata", udp_tx_tdata, 64'he0);
    chk("t5_regrant_tkeep", 64'(udp_tx_tkeep), 64'h0f);
    tick();
    data_tvalid = 1'b0;
    #1;
    chk("t5_data_cnt_after", 64'(data_pkt_cnt), 64'd1);

    // 6: 1000 single-beat data packets back to back
    rst();
    data_tvalid = 1'b1; data_tlast = 1'b1;
    nf = 0; last_c = -1; prev_c = -1; bad_gap = 0;
    for (int c = 0; c < 2100; c++) begin
      #1;
      if (data_tvalid && data_tready) begin
        if (prev_c >= 0 && c - prev_c != 2) bad_gap++;
        prev_c = c; last_c = c; nf++;
      end
      if (nf == 1000) break;
      tick();
    end
    chk("t6_nfires", 64'(nf), 64'd1000);
    chk("t6_bad_gaps", 64'(bad_gap), 64'd0);
    chk("t6_last_cycle", 64'(last_c), 64'd1999);
    tick();
    data_tvalid = 1'b0;
    #1;
    chk("t6_data_cnt", 64'(data_pkt_cnt), 64'd1000);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
